sram_data_controller: RTL

- Responder side of the MEM-stage data-memory interface: accepts one 32-bit word read or write request from the MEM stage.
- Executes the request as two sequential 16-bit accesses on an external single-port SRAM, each phase lasting WAIT_CYCLES.
- Drives ready low while busy; the top level uses ~ready to freeze the whole pipeline.
- Sits between the MEM stage and the SRAM pins.

---
 rtl/sram_data_controller.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/sram_data_controller.sv
// MEM-stage data-memory responder: turns one 32-bit read/write request into two
// 16-bit phases on an external single-port SRAM, holding ready low while busy.
module sram_data_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdEn,
  input  logic               wrEn,
  input  logic [31:0]        address,
  input  logic [31:0]        writeData,
  output logic [31:0]        readData,
  output logic               ready,
  output logic [SRAM_AW-1:0] sramAddr,
  output logic               sramWeN,
  output logic [15:0]        sramDqOut,
  output logic               sramDqOe,
  input  logic [15:0]        sramDqIn
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] BASE_C   = 32'(BASE_ADDR);
  localparam logic [3:0]  RELOAD_C = 4'(WAIT_CYCLES - 1);

  state_t               state_r, nextState_s;
  logic [3:0]           count_r, nextCount_s;
  logic                 isWrite_r, nextIsWrite_s;
  logic [SRAM_AW-2:0]   word_r, nextWord_s;
  logic [31:0]          data_r, nextData_s;
  logic [15:0]          lowTemp_r, nextLowTemp_s;
  logic [31:0]          nextReadData_s;
  logic [SRAM_AW-1:0]   nextSramAddr_s;
  logic                 nextWeN_s;
  logic                 nextOe_s;
  logic [15:0]          nextDqOut_s;
  logic                 req_s;
  logic [31:0]          offset_s;
  logic                 unusedOffset_s;

  assign req_s          = rdEn | wrEn;
  assign offset_s       = address - BASE_C;
  assign unusedOffset_s = ^{offset_s[31:SRAM_AW+1], offset_s[1:0]};
  assign ready          = ((state_r == IDLE) && !req_s) || (state_r == DONE);

  // Next-state, request latching, and the SRAM pin values for the state being entered.
  always_comb begin
    nextState_s    = state_r;
    nextCount_s    = count_r;
    nextIsWrite_s  = isWrite_r;
    nextWord_s     = word_r;
    nextData_s     = data_r;
    nextLowTemp_s  = lowTemp_r;
    nextReadData_s = readData;
    nextSramAddr_s = sramAddr;
    nextWeN_s      = 1'b1;
    nextOe_s       = 1'b0;
    nextDqOut_s    = sramDqOut;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          nextState_s   = LO;
          nextCount_s   = RELOAD_C;
          nextIsWrite_s = wrEn;
          nextWord_s    = offset_s[SRAM_AW:2];
          nextData_s    = writeData;
        end else begin
          nextState_s = IDLE;
        end
      end
      LO: begin
        if (count_r == 4'd0) begin
          nextState_s = HI;
          nextCount_s = RELOAD_C;
          if (isWrite_r) begin
            nextLowTemp_s = lowTemp_r;
          end else begin
            nextLowTemp_s = sramDqIn;
          end
        end else begin
          nextCount_s = count_r - 4'd1;
        end
      end
      HI: begin
        if (count_r == 4'd0) begin
          nextState_s = DONE;
          if (isWrite_r) begin
            nextReadData_s = readData;
          end else begin
            nextReadData_s = {sramDqIn, lowTemp_r};
          end
        end else begin
          nextCount_s = count_r - 4'd1;
        end
      end
      DONE:    nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
    // Pins are registered, so they are computed from the state about to be entered.
    case (nextState_s)
      LO: begin
        nextSramAddr_s = {nextWord_s, 1'b0};
        nextWeN_s      = ~nextIsWrite_s;
        nextOe_s       = nextIsWrite_s;
        if (nextIsWrite_s) begin
          nextDqOut_s = nextData_s[15:0];
        end else begin
          nextDqOut_s = sramDqOut;
        end
      end
      HI: begin
        nextSramAddr_s = {nextWord_s, 1'b1};
        nextWeN_s      = ~nextIsWrite_s;
        nextOe_s       = nextIsWrite_s;
        if (nextIsWrite_s) begin
          nextDqOut_s = nextData_s[31:16];
        end else begin
          nextDqOut_s = sramDqOut;
        end
      end
      default: begin
        nextWeN_s = 1'b1;
        nextOe_s  = 1'b0;
      end
    endcase
  end

  // State, latched request and registered SRAM pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      count_r   <= 4'd0;
      isWrite_r <= 1'b0;
      word_r    <= '0;
      data_r    <= 32'd0;
      lowTemp_r <= 16'd0;
      readData  <= 32'd0;
      sramAddr  <= '0;
      sramWeN   <= 1'b1;
      sramDqOut <= 16'd0;
      sramDqOe  <= 1'b0;
    end else begin
      state_r   <= nextState_s;
      count_r   <= nextCount_s;
      isWrite_r <= nextIsWrite_s;
      word_r    <= nextWord_s;
      data_r    <= nextData_s;
      lowTemp_r <= nextLowTemp_s;
      readData  <= nextReadData_s;
      sramAddr  <= nextSramAddr_s;
      sramWeN   <= nextWeN_s;
      sramDqOut <= nextDqOut_s;
      sramDqOe  <= nextOe_s;
    end
  end

endmodule
